// File: rtl/l2_arbiter.sv
// Two-client (L1 I / L1 D) line-miss arbiter in front of the L2 controller; optional L2_ARB_ROUND_ROBIN_EN.
// Latency: a request seen in IDLE reaches L2 one cycle later; the response is returned combinationally.
// Backpressure: clients hold requests until their resp; one latched transaction, then a 1-cycle GAP.
module l2_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic              l2_resp,
    input  logic [LINE_W-1:0] l2_rdata
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        GAP     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_t;

    state_t            state;
    state_t            state_nxt;
    op_t               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              i_pend;
    logic              d_pend;
    logic              grant_vld;
    logic              grant_d;

    assign i_pend    = i_read;
    assign d_pend    = d_read | d_write;
    assign grant_vld = (state == IDLE) && (i_pend || d_pend);

`ifdef L2_ARB_ROUND_ROBIN_EN
    // last_grant_d = 0 means I was granted last; a conflict goes to the other client.
    logic last_grant_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_d <= 1'b0;
        end else if (grant_vld) begin
            last_grant_d <= grant_d;
        end
    end

    assign grant_d = d_pend && (!i_pend || !last_grant_d);
`else
    assign grant_d = d_pend;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    state_nxt = grant_d ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (l2_resp) begin
                    state_nxt = GAP;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Transaction latch: client inputs may change freely once granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= OP_NONE;
        end else if (grant_vld) begin
            if (grant_d) begin
                addr_q  <= d_addr;
                wdata_q <= d_wdata;
                op_q    <= d_write ? OP_WRITE : OP_READ;
            end else begin
                addr_q  <= i_addr;
                op_q    <= OP_READ;
            end
        end
    end

    assign l2_addr  = addr_q;
    assign l2_wdata = wdata_q;

    always_comb begin
        l2_read  = 1'b0;
        l2_write = 1'b0;
        i_resp   = 1'b0;
        d_resp   = 1'b0;
        i_rdata  = '0;
        d_rdata  = '0;
        case (state)
            SERVE_I: begin
                l2_read  = (op_q == OP_READ);
                l2_write = (op_q == OP_WRITE);
                i_resp   = l2_resp;
                i_rdata  = l2_resp ? l2_rdata : '0;
            end
            SERVE_D: begin
                l2_read  = (op_q == OP_READ);
                l2_write = (op_q == OP_WRITE);
                d_resp   = l2_resp;
                d_rdata  = l2_resp ? l2_rdata : '0;
            end
            default: begin
                l2_read  = 1'b0;
                l2_write = 1'b0;
            end
        endcase
    end

endmodule
